mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory port of the multi-cycle RISC-V core between the instruction-fetch requester and the load/store requester. Every access runs through a small FSM with a req/ready handshake to variable-latency memory. Store byte strobes are generated from the control unit's `storeCtrl` encoding. Each completed access is returned to its owner as a one-cycle done pulse with the registered read word.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width; fixed at 32 (4 byte lanes)

Ports:
- `clk`  in  1  rising-edge clock
- `rstn`  in  1  asynchronous reset, active-low
- `fetchReq`  in  1  fetch request; held until `fetchDone`
- `fetchAddr`  in  ADDR_W  fetch address (word aligned)
- `fetchRdata`  out  DATA_W  fetched word; valid while `fetchDone`=1
- `fetchDone`  out  1  one-cycle completion pulse
- `dataReq`  in  1  load/store request; held until `dataDone`
- `dataAddr`  in  ADDR_W  byte address
- `dataWe`  in  1  1 = store (`memWrite`), 0 = load
- `storeCtrl`  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- `dataWdata`  in  DATA_W  store data, LSB-justified
- `dataRdata`  out  DATA_W  raw loaded word; `loadCtrl` extraction stays downstream
- `dataDone`  out  1  one-cycle completion pulse
- `misalign`  out  1  one-cycle pulse; the store was rejected
- `memReq`  out  1  memory access request
- `memAddr`  out  ADDR_W  word address; bits [1:0] are forced to 0
- `memWe`  out  1  write enable
- `memWstrb`  out  4  byte strobes
- `memWdata`  out  DATA_W  lane-replicated store data
- `memRdata`  in  DATA_W  read word
- `memReady`  in  1  access completes in the cycle it is sampled high
- `busy`  out  1  state != IDLE

## Operation
- States:
  - IDLE, FETCH, DATA.
  - `memReq` = (state == FETCH or DATA).
  - memAddr/memWe/memWstrb/memWdata come from registers loaded on grant and stay stable until `memReady`.
- Grant from IDLE:
  - Eligible requester: `req`=1 and its own `done`=0 in the same cycle. This masks a requester that is still holding req during its done cycle.
  - Both eligible: DATA wins (default priority).
  - Fetch grant: latch `{fetchAddr[ADDR_W-1:2],2'b00}`, set memWe=0, memWstrb=0000, go to FETCH.
  - Data grant: latch address, we, strobes and wdata, go to DATA.
  - A misaligned store does not leave IDLE. It pulses `misalign` and `dataDone` next cycle, and memory is untouched.
- Strobes and lanes (stores):
  - byte: `0001 << addr[1:0]`, wdata[7:0] replicated to all 4 lanes.
  - half: `0011 << {addr[1],1'b0}`, wdata[15:0] replicated twice.
  - word: `1111`, wdata unchanged.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - Loads: strobes 0000, full word returned regardless of alignment.
- Completion in FETCH/DATA with `memReady`=1:
  - Register `memRdata` into the owner's rdata.
  - Set owner's done=1 for the next cycle.
  - Go to IDLE.
- rdata registers hold their value between accesses. Store completions leave `dataRdata` unchanged.
- `memReady` while IDLE is ignored.

## Timing
- Reset (async, immediate): state IDLE, all outputs 0 (memReq, memAddr, memWe, memWstrb, memWdata, fetchRdata, dataRdata, both done, misalign, busy).
- Request first sampled at edge 0 -> memReq high after edge 0 -> `memReady` sampled at edge k (k ≥ 1) -> done high for exactly the cycle after edge k.
- Zero-wait memory: done 2 cycles after request sampling.
- Back-to-back: the done cycle is an IDLE cycle, so the other requester can be granted there. Per-port throughput is 1 access / 3 cycles.
- Misaligned store: `misalign` and `dataDone` in the cycle after sampling.
- `rstn` low mid-access abandons the transaction. memReq drops asynchronously, and no done pulse is generated for it.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Contention resolved round-robin through a `lastGrant` flop.
  - `lastGrant` resets to DATA, so the first contended grant goes to fetch; it updates on every grant.
- Undefined: fixed data-over-fetch priority, no extra state.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/FETCH/DATA)
  - `storeCtrl` encoding constants (ST_BYTE/ST_HALF/ST_WORD)
  - grant-id constants (GNT_FETCH/GNT_DATA)
- Sub-module `store_lane_align` (combinational) takes addr[1:0], storeCtrl and wdata, and produces wstrb, replicated wdata and misalign.

## Test plan
- Fetch only, addr 0x0000_0104, memReady tied 1 -> memReq one cycle, memAddr 0x104, fetchDone 2 cycles after request, fetchRdata = memRdata.
- Simultaneous fetch and load, addr 0x200 -> DATA served first, then fetch granted in the dataDone cycle. With `MEM_ARB_RR_EN`, the first contention after reset serves fetch first.
- Store byte: addr 0x103, wdata 0x0000_00AB -> memWstrb 1000, memWdata 0xABAB_ABAB, memAddr 0x100. Store half at 0x102, wdata 0x1234 -> wstrb 1100, memWdata 0x1234_1234.
- Store word at 0x202 -> misalign and dataDone pulse 1 cycle, memReq never asserted.
- memReady held low 5 cycles -> memReq and addr stable throughout, done exactly once. `rstn` pulsed low mid-wait -> all outputs 0 immediately, no done pulse afterwards.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arbState_t;

  localparam logic [1:0] ST_BYTE = 2'b00;
  localparam logic [1:0] ST_HALF = 2'b01;
  localparam logic [1:0] ST_WORD = 2'b10;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/store_lane_align.sv
// Combinational store lane steering: byte strobes, lane-replicated write data
// and misalignment detection from the low address bits and storeCtrl.
module store_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  byteOffset,
  input  logic [1:0]  storeCtrl,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] laneData,
  output logic        misalign
);

  // NOTE: every output gets a default first so no path through the case
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    wstrb    = 4'b0000;
    laneData = wdata;
    misalign = 1'b0;
    case (storeCtrl)
      ST_BYTE: begin
        wstrb    = 4'b0001 << byteOffset;
        laneData = {4{wdata[7:0]}};
      end
      ST_HALF: begin
        wstrb    = 4'b0011 << {byteOffset[1], 1'b0};
        laneData = {2{wdata[15:0]}};
        misalign = byteOffset[0];
      end
      default: begin
        // Reserved encoding behaves as a full word store.
        wstrb    = 4'b1111;
        misalign = |byteOffset;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store via a
// req/ready FSM. Define MEM_ARB_RR_EN for round-robin instead of data priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic [DATA_W-1:0] fetchRdata,
  output logic              fetchDone,
  input  logic              dataReq,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic              dataWe,
  input  logic [1:0]        storeCtrl,
  input  logic [DATA_W-1:0] dataWdata,
  output logic [DATA_W-1:0] dataRdata,
  output logic              dataDone,
  output logic              misalign,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWe,
  output logic [3:0]        memWstrb,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memReady,
  output logic              busy
);

  arbState_t         state, nextState;
  logic              fetchElig, dataElig, pickData;
  logic              grantFetch, grantData, dataReject;
  logic [3:0]        alignStrb;
  logic [DATA_W-1:0] alignData;
  logic              alignMisalign;
  logic              unusedFetchLsb;

  assign unusedFetchLsb = ^fetchAddr[1:0];

  store_lane_align uAlign (
    .byteOffset (dataAddr[1:0]),
    .storeCtrl  (storeCtrl),
    .wdata      (dataWdata),
    .wstrb      (alignStrb),
    .laneData   (alignData),
    .misalign   (alignMisalign)
  );

`ifdef MEM_ARB_RR_EN
  logic lastGrant;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           lastGrant <= GNT_DATA;
    else if (grantData)  lastGrant <= GNT_DATA;
    else if (grantFetch) lastGrant <= GNT_FETCH;
  end
`endif

  // A requester still holding req during its own done cycle is not eligible.
  always_comb begin
    fetchElig = fetchReq & ~fetchDone;
    dataElig  = dataReq & ~dataDone;
`ifdef MEM_ARB_RR_EN
    pickData  = dataElig & (~fetchElig | (lastGrant == GNT_FETCH));
`else
    pickData  = dataElig;
`endif
    grantData  = (state == IDLE) & pickData;
    grantFetch = (state == IDLE) & fetchElig & ~pickData;
    dataReject = grantData & dataWe & alignMisalign;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (grantData && !dataReject) nextState = DATA;
        else if (grantFetch)          nextState = FETCH;
      end
      FETCH, DATA: if (memReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    memReq = (state == FETCH) || (state == DATA);
    busy   = (state != IDLE);
  end

  // Access registers are loaded on grant and held until the access completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      memAddr    <= '0;
      memWe      <= 1'b0;
      memWstrb   <= 4'b0000;
      memWdata   <= '0;
      fetchRdata <= '0;
      dataRdata  <= '0;
      fetchDone  <= 1'b0;
      dataDone   <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      fetchDone <= (state == FETCH) && memReady;
      dataDone  <= ((state == DATA) && memReady) || dataReject;
      misalign  <= dataReject;
      if (grantFetch) begin
        memAddr  <= {fetchAddr[ADDR_W-1:2], 2'b00};
        memWe    <= 1'b0;
        memWstrb <= 4'b0000;
      end else if (grantData && !dataReject) begin
        memAddr  <= {dataAddr[ADDR_W-1:2], 2'b00};
        memWe    <= dataWe;
        memWstrb <= dataWe ? alignStrb : 4'b0000;
        memWdata <= alignData;
      end
      if (state == FETCH && memReady) fetchRdata <= memRdata;
      if (state == DATA && memReady && !memWe) dataRdata <= memRdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; memory returns addr ^ C0DE0000.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetchReq, dataReq, dataWe, memReady;
  logic [31:0] fetchAddr, dataAddr, dataWdata;
  logic [1:0]  storeCtrl;
  logic [31:0] fetchRdata, dataRdata, memAddr, memWdata, memRdata;
  logic        fetchDone, dataDone, misalign, memReq, memWe, busy;
  logic [3:0]  memWstrb;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchRdata(fetchRdata), .fetchDone(fetchDone),
    .dataReq(dataReq), .dataAddr(dataAddr), .dataWe(dataWe), .storeCtrl(storeCtrl),
    .dataWdata(dataWdata), .dataRdata(dataRdata), .dataDone(dataDone), .misalign(misalign),
    .memReq(memReq), .memAddr(memAddr), .memWe(memWe), .memWstrb(memWstrb),
    .memWdata(memWdata), .memRdata(memRdata), .memReady(memReady), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memModel(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign memRdata = memModel(memAddr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runStore(input string tag, input logic [31:0] addr, input logic [1:0] ctrl,
                          input logic [31:0] wd, input logic [3:0] expStrb,
                          input logic [31:0] expData, input logic [31:0] expRdata);
    dataReq = 1'b1; dataWe = 1'b1; dataAddr = addr; storeCtrl = ctrl; dataWdata = wd;
    tick();
    check({tag, ".req"},   memReq, 1'b1);
    check({tag, ".addr"},  memAddr, {addr[31:2], 2'b00});
    check({tag, ".we"},    memWe, 1'b1);
    check({tag, ".strb"},  memWstrb, expStrb);
    check({tag, ".wdata"}, memWdata, expData);
    tick();
    check({tag, ".done"},  dataDone, 1'b1);
    check({tag, ".rdata"}, dataRdata, expRdata);
    dataReq = 1'b0; dataWe = 1'b0;
    tick();
    check({tag, ".done_low"}, dataDone, 1'b0);
  endtask

  initial begin
    logic        firstIsData;
    logic [31:0] firstAddr, secondAddr, heldRdata;

`ifdef MEM_ARB_RR_EN
    firstIsData = 1'b0;
`else
    firstIsData = 1'b1;
`endif
    rstn = 1'b0; fetchReq = 1'b0; dataReq = 1'b0; dataWe = 1'b0; memReady = 1'b1;
    fetchAddr = '0; dataAddr = '0; dataWdata = '0; storeCtrl = ST_WORD;
    #3;
    check("rst.memReq", memReq, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.memAddr", memAddr, 32'h0);
    check("rst.memWstrb", memWstrb, 4'h0);
    check("rst.memWdata", memWdata, 32'h0);
    check("rst.dones", {fetchDone, dataDone, misalign, memWe}, 4'h0);
    check("rst.rdata", fetchRdata | dataRdata, 32'h0);
    @(negedge clk) rstn = 1'b1;
    tick();

    // Contention: fetch 0x108 vs load 0x200.
    fetchReq = 1'b1; fetchAddr = 32'h108;
    dataReq = 1'b1; dataAddr = 32'h200; dataWe = 1'b0; storeCtrl = ST_WORD;
    firstAddr  = firstIsData ? 32'h200 : 32'h108;
    secondAddr = firstIsData ? 32'h108 : 32'h200;
    tick();
    check("arb.first_req", memReq, 1'b1);
    check("arb.first_addr", memAddr, firstAddr);
    check("arb.first_we", {memWe, memWstrb}, 5'h0);
    tick();
    check("arb.first_done", firstIsData ? dataDone : fetchDone, 1'b1);
    check("arb.other_quiet", firstIsData ? fetchDone : dataDone, 1'b0);
    check("arb.idle_in_done", memReq, 1'b0);
    if (firstIsData) dataReq = 1'b0; else fetchReq = 1'b0;
    tick();
    check("arb.second_req", memReq, 1'b1);
    check("arb.second_addr", memAddr, secondAddr);
    tick();
    check("arb.second_done", firstIsData ? fetchDone : dataDone, 1'b1);
    check("arb.fetch_rdata", fetchRdata, memModel(32'h108));
    check("arb.data_rdata", dataRdata, memModel(32'h200));
    fetchReq = 1'b0; dataReq = 1'b0;
    tick();
    check("arb.quiet", {fetchDone, dataDone, memReq}, 3'b000);

    // Fetch only at 0x104, zero-wait memory.
    fetchReq = 1'b1; fetchAddr = 32'h104;
    tick();
    check("fetch.req", memReq, 1'b1);
    check("fetch.addr", memAddr, 32'h104);
    check("fetch.done_early", fetchDone, 1'b0);
    tick();
    check("fetch.done", fetchDone, 1'b1);
    check("fetch.rdata", fetchRdata, memModel(32'h104));
    check("fetch.req_drop", memReq, 1'b0);
    fetchReq = 1'b0;
    tick();
    check("fetch.single_pulse", fetchDone, 1'b0);
    tick();
    check("fetch.ready_idle_ignored", {fetchDone, dataDone, busy}, 3'b000);
    check("fetch.rdata_hold", fetchRdata, memModel(32'h104));

    // Stores: lane steering; dataRdata must keep the last load value.
    heldRdata = memModel(32'h200);
    runStore("st_b3", 32'h103, ST_BYTE, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, heldRdata);
    runStore("st_b1", 32'h101, ST_BYTE, 32'hFFFF_FF5C, 4'b0010, 32'h5C5C_5C5C, heldRdata);
    runStore("st_h2", 32'h102, ST_HALF, 32'h0000_1234, 4'b1100, 32'h1234_1234, heldRdata);
    runStore("st_h0", 32'h100, ST_HALF, 32'h0000_BEEF, 4'b0011, 32'hBEEF_BEEF, heldRdata);
    runStore("st_w",  32'h204, ST_WORD, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, heldRdata);
    runStore("st_rsv", 32'h208, 2'b11,  32'h0BAD_CAFE, 4'b1111, 32'h0BAD_CAFE, heldRdata);

    // Misaligned stores are rejected without touching memory.
    for (int i = 0; i < 2; i++) begin
      dataReq = 1'b1; dataWe = 1'b1; dataWdata = 32'h1111_2222;
      dataAddr  = (i == 0) ? 32'h202 : 32'h101;
      storeCtrl = (i == 0) ? ST_WORD : ST_HALF;
      tick();
      check("mis.pulse", misalign, 1'b1);
      check("mis.done", dataDone, 1'b1);
      check("mis.no_req", {memReq, busy}, 2'b00);
      dataReq = 1'b0; dataWe = 1'b0;
      tick();
      check("mis.clear", {misalign, dataDone, memReq}, 3'b000);
      check("mis.addr_kept", memAddr, 32'h208);
    end

    // Slow memory: request held stable through 5 wait cycles.
    memReady = 1'b0;
    dataReq = 1'b1; dataWe = 1'b0; dataAddr = 32'h301; storeCtrl = ST_BYTE;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("wait.req", memReq, 1'b1);
      check("wait.addr", memAddr, 32'h300);
      check("wait.no_done", dataDone, 1'b0);
      tick();
    end
    memReady = 1'b1;
    tick();
    check("wait.done", dataDone, 1'b1);
    check("wait.rdata", dataRdata, memModel(32'h300));
    dataReq = 1'b0;
    tick();
    check("wait.once", dataDone, 1'b0);

    // Reset mid-wait abandons the fetch.
    memReady = 1'b0;
    fetchReq = 1'b1; fetchAddr = 32'h400;
    tick();
    tick();
    check("rw.req_before", memReq, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("rw.req_async", memReq, 1'b0);
    check("rw.busy", busy, 1'b0);
    check("rw.addr", memAddr, 32'h0);
    check("rw.rdata", fetchRdata | dataRdata, 32'h0);
    fetchReq = 1'b0;
    memReady = 1'b1;
    @(negedge clk) rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rw.no_done", {fetchDone, dataDone, memReq}, 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
